// File: rtl/pio_step_sequencer_pkg.sv
// Shared types and default constants for the PIO step sequencer.
package pio_step_sequencer_pkg;

    // Handshake states of the step issuer.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_PEND_W      = 4;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/pio_edge_sync.sv
// Synchronises the software-toggled PIO bit and reports its edges once armed.
// Optional: PIO_STEP_BOTH_EDGES_EN makes falling edges count as well as rising.
module pio_edge_sync
    import pio_step_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pio_clock_in,
    output logic edge_seen
);

    // Enough bits to count up to SYNC_STAGES+1.
    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   synced;
    logic                   armed;
    logic                   raw_edge;

    assign synced = sync_chain[SYNC_STAGES-1];
    assign armed  = (arm_cnt == ARM_DONE);

    // Synchroniser shift, previous-sample register and post-reset arming count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values;
            // blocking here would collapse the synchroniser into a single stage.
            sync_chain <= '0;
            prev       <= 1'b0;
            arm_cnt    <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pio_clock_in};
            prev       <= synced;
            if (arm_cnt != ARM_DONE) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    // Edge qualifier; masked until the chain holds only post-reset samples.
    always_comb begin
`ifdef PIO_STEP_BOTH_EDGES_EN
        raw_edge = synced ^ prev;
`else
        raw_edge = synced & ~prev;
`endif
        edge_seen = raw_edge & armed;
    end

endmodule

// File: rtl/pio_step_sequencer.sv
// Turns PIO edges into queued single steps for the iteration/draw engine,
// issued one at a time over a valid/ready/done handshake.
// Optional: PIO_STEP_BOTH_EDGES_EN (handled in pio_edge_sync).
module pio_step_sequencer
    import pio_step_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int PEND_W      = DEF_PEND_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pio_clock_in,
    output logic              step_valid,
    input  logic              step_ready,
    input  logic              step_done,
    input  logic              clear_overflow,
    output logic [CNT_W-1:0]  step_count,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state;
    state_t            state_next;
    logic              edge_seen;
    logic              handshake;
    logic [PEND_W-1:0] pending_next;
    logic              overflow_set;
    logic              valid_next;

    pio_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .pio_clock_in (pio_clock_in),
        .edge_seen    (edge_seen)
    );

    // step_valid is only ever high in ISSUE, so ready without valid does nothing.
    assign handshake = step_valid & step_ready;

    // Next pending value: an edge and an accept in the same cycle cancel out.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        pending_next = pending;
        overflow_set = 1'b0;
        case ({edge_seen, handshake})
            2'b10: begin
                if (pending == PEND_MAX) begin
                    overflow_set = 1'b1;
                end else begin
                    pending_next = pending + PEND_W'(1);
                end
            end
            2'b01:   pending_next = pending - PEND_W'(1);
            default: pending_next = pending;
        endcase
    end

    // Pending queue depth, accepted-step count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending    <= '0;
            step_count <= '0;
            overflow   <= 1'b0;
        end else begin
            pending <= pending_next;
            if (handshake) begin
                step_count <= step_count + CNT_W'(1);
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // State register plus the registered copy of step_valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            step_valid <= 1'b0;
        end else begin
            state      <= state_next;
            step_valid <= valid_next;
        end
    end

    // Next-state logic: at most one step outstanding at any time.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (step_done) begin
                    state_next = (pending_next != '0) ? ISSUE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the next state so step_valid leaves a flop.
    always_comb begin
        valid_next = (state_next == ISSUE);
    end

    assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_pio_step_sequencer.sv
// Self-checking bench for pio_step_sequencer: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_pio_step_sequencer;

    localparam int S = 2;

`ifdef PIO_STEP_BOTH_EDGES_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pio_clock_in = 1'b0;
    logic        step_valid;
    logic        step_ready = 1'b0;
    logic        step_done = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [31:0] step_count;
    logic [3:0]  pending;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_step_sequencer #(
        .SYNC_STAGES (S),
        .PEND_W      (4),
        .CNT_W       (32)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pio_clock_in   (pio_clock_in),
        .step_valid     (step_valid),
        .step_ready     (step_ready),
        .step_done      (step_done),
        .clear_overflow (clear_overflow),
        .step_count     (step_count),
        .pending        (pending),
        .busy           (busy),
        .overflow       (overflow)
    );

    // ---------------- reference model ----------------
    // Samples of pio_clock_in since reset release; sample n (1-based) was
    // taken at the n-th non-reset clock edge. An input change taken at sample
    // k is counted S edges later, and only once S+1 edges have passed since
    // release (so samples from before release never count).
    bit          samp[$];
    logic [3:0]  m_pend;
    logic [31:0] m_cnt;
    bit          m_ovf;
    bit          m_valid;
    bit          m_out;
    int          m_n;
    bit          m_a, m_b, m_inc, m_hs, m_set;
    logic [3:0]  m_pn;

    function automatic bit smp(int j);
        if (j < 1) return 1'b0;
        return samp[j-1];
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            samp.delete();
            m_pend  = '0;
            m_cnt   = '0;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_out   = 1'b0;
        end else begin
            samp.push_back(pio_clock_in);
            m_n   = samp.size();
            m_a   = smp(m_n - S);
            m_b   = smp(m_n - S - 1);
            m_inc = (m_n - 1 >= S + 1) && (BOTH ? (m_a != m_b) : (m_a && !m_b));
            m_hs  = m_valid && step_ready;
            m_pn  = m_pend;
            m_set = 1'b0;
            if (m_inc && !m_hs) begin
                if (m_pend == 4'd15) m_set = 1'b1;
                else                 m_pn = m_pend + 4'd1;
            end else if (!m_inc && m_hs) begin
                m_pn = m_pend - 4'd1;
            end
            if (m_set)               m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
            if (m_hs) m_cnt = m_cnt + 32'd1;
            if (m_valid) begin
                if (m_hs) begin
                    m_valid = 1'b0;
                    m_out   = 1'b1;
                end
            end else if (m_out) begin
                if (step_done) begin
                    m_out   = 1'b0;
                    m_valid = (m_pn != 4'd0);
                end
            end else begin
                m_valid = (m_pend != 4'd0);
            end
            m_pend = m_pn;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input bit lvl);
        @(negedge clk);
        reset_n        = 1'b0;
        pio_clock_in   = lvl;
        step_ready     = 1'b0;
        step_done      = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_armed();
        repeat (S + 4) @(negedge clk);
    endtask

    // n detectable edges: toggles when both edges count, pulses otherwise.
    task automatic make_edges(input int n);
        for (int i = 0; i < n; i++) begin
            if (BOTH) begin
                pio_clock_in = ~pio_clock_in;
                repeat (3) @(negedge clk);
            end else begin
                pio_clock_in = 1'b1;
                repeat (3) @(negedge clk);
                pio_clock_in = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (pending !== 4'd0) begin
                errors++;
                $display("FAIL reset_pending cyc%0d: got %0d expected 0", i, pending);
            end
            checks++;
            if (step_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid cyc%0d: got %b expected 0", i, step_valid);
            end
            checks++;
            if (busy !== 1'b0 || overflow !== 1'b0 || step_count !== 32'd0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: busy=%b ovf=%b cnt=%0d expected 0/0/0",
                         i, busy, overflow, step_count);
            end
        end
    endtask

    task automatic test_single_step();
        do_reset(1'b0);
        wait_armed();
        step_ready   = 1'b1;
        pio_clock_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (step_valid !== (k == 3)) begin
                errors++;
                $display("FAIL latency edge+%0d: got valid=%b expected %b", k, step_valid, (k == 3));
            end
        end
        @(negedge clk);
        checks++;
        if (step_count !== 32'd1 || step_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: cnt=%0d valid=%b busy=%b expected 1/0/1",
                     step_count, step_valid, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_wait: got %b expected 1", busy);
        end
        step_done = 1'b1;
        @(negedge clk);
        step_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || step_valid !== 1'b0 || step_count !== 32'd1 || pending !== 4'd0) begin
            errors++;
            $display("FAIL single_done: busy=%b valid=%b cnt=%0d pend=%0d expected 0/0/1/0",
                     busy, step_valid, step_count, pending);
        end
    endtask

    task automatic test_saturation();
        int steps;
        int budget;
        do_reset(1'b0);
        wait_armed();
        make_edges(20);
        repeat (6) @(negedge clk);
        checks++;
        if (pending !== 4'd15) begin
            errors++;
            $display("FAIL sat_pending: got %0d expected 15", pending);
        end
        checks++;
        if (overflow !== 1'b1 || step_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_flags: ovf=%b valid=%b expected 1/1", overflow, step_valid);
        end
        step_ready = 1'b1;
        steps  = 0;
        budget = 0;
        while (steps < 15 && budget < 200) begin
            if (step_valid === 1'b1) begin
                @(negedge clk);
                steps++;
                step_done = 1'b1;
                @(negedge clk);
                step_done = 1'b0;
            end else begin
                @(negedge clk);
            end
            budget++;
        end
        checks++;
        if (budget >= 200) begin
            errors++;
            $display("FAIL sat_drain_timeout: served %0d steps expected 15", steps);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (step_count !== 32'd15) begin
            errors++;
            $display("FAIL sat_count: got %0d expected 15", step_count);
        end
        checks++;
        if (pending !== 4'd0 || step_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_drained: pend=%0d valid=%b busy=%b ovf=%b expected 0/0/0/1",
                     pending, step_valid, busy, overflow);
        end
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(1'b0);
        wait_armed();
        make_edges(3);
        repeat (6) @(negedge clk);
        checks++;
        if (pending !== 4'd3 || step_valid !== 1'b1) begin
            errors++;
            $display("FAIL simul_setup: pend=%0d valid=%b expected 3/1", pending, step_valid);
        end
        pio_clock_in = ~pio_clock_in;
        repeat (2) @(negedge clk);
        step_ready = 1'b1;
        @(negedge clk);
        step_ready = 1'b0;
        checks++;
        if (pending !== 4'd3 || step_count !== 32'd1 || step_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_edge_and_accept: pend=%0d cnt=%0d valid=%b expected 3/1/0",
                     pending, step_count, step_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        wait_armed();
        step_ready = 1'b1;
        make_edges(3);
        repeat (6) @(negedge clk);
        checks++;
        if (pending !== 4'd2 || step_valid !== 1'b0 || busy !== 1'b1 || step_count !== 32'd1) begin
            errors++;
            $display("FAIL midreset_setup: pend=%0d valid=%b busy=%b cnt=%0d expected 2/0/1/1",
                     pending, step_valid, busy, step_count);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (pending !== 4'd0 || step_valid !== 1'b0 || busy !== 1'b0 ||
            step_count !== 32'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: pend=%0d valid=%b busy=%b cnt=%0d ovf=%b expected all 0",
                     pending, step_valid, busy, step_count, overflow);
        end
        reset_n   = 1'b1;
        step_done = 1'b1;
        @(negedge clk);
        step_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (step_valid !== 1'b0 || busy !== 1'b0 || step_count !== 32'd0) begin
            errors++;
            $display("FAIL midreset_late_done: valid=%b busy=%b cnt=%0d expected 0/0/0",
                     step_valid, busy, step_count);
        end
    endtask

    task automatic test_both_edges();
        do_reset(1'b0);
        wait_armed();
        step_ready   = 1'b1;
        step_done    = 1'b1;  // only meaningful while a step is outstanding
        pio_clock_in = 1'b1;
        repeat (6) @(negedge clk);
        pio_clock_in = 1'b0;
        repeat (12) @(negedge clk);
        step_done  = 1'b0;
        step_ready = 1'b0;
        checks++;
        if (step_count !== (BOTH ? 32'd2 : 32'd1)) begin
            errors++;
            $display("FAIL edge_mode_steps: got %0d expected %0d", step_count, (BOTH ? 2 : 1));
        end
        checks++;
        if (busy !== 1'b0 || pending !== 4'd0) begin
            errors++;
            $display("FAIL edge_mode_idle: busy=%b pend=%0d expected 0/0", busy, pending);
        end
    endtask

    task automatic test_random();
        do_reset(1'b0);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if (step_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_valid cyc%0d: got %b expected %b", i, step_valid, m_valid);
            end
            checks++;
            if (pending !== m_pend) begin
                errors++;
                $display("FAIL rand_pending cyc%0d: got %0d expected %0d", i, pending, m_pend);
            end
            checks++;
            if (step_count !== m_cnt) begin
                errors++;
                $display("FAIL rand_count cyc%0d: got %0d expected %0d", i, step_count, m_cnt);
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_overflow cyc%0d: got %b expected %b", i, overflow, m_ovf);
            end
            checks++;
            if (busy !== (m_valid || m_out || (m_pend != 4'd0))) begin
                errors++;
                $display("FAIL rand_busy cyc%0d: got %b expected %b", i, busy,
                         (m_valid || m_out || (m_pend != 4'd0)));
            end
            if ($urandom_range(0, 3) == 0) pio_clock_in = ~pio_clock_in;
            step_ready     = ($urandom_range(0, 2) == 0);
            step_done      = ($urandom_range(0, 3) == 0);
            clear_overflow = ($urandom_range(0, 31) == 0);
            reset_n        = ($urandom_range(0, 599) != 0);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_step();
        test_saturation();
        test_simultaneous();
        test_reset_mid();
        test_both_edges();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
